// File: rtl/bit_stream_monitor.sv
// -----------------------------------------------------------------------------
// bit_stream_monitor
//
// Receive-side consumer for the single-bit generator stream. Accepted bits are
// packed MSB-first into bytes for downstream logic. Two online health tests run
// on the same bits:
//   - repetition-count test (RCT): flags a run of RCT_CUTOFF identical bits
//   - adaptive-proportion test (APT): over each WIN-bit window, counts bits
//     equal to the window's first bit and flags a count >= APT_CUTOFF
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   bit_in      stream bit
//   bit_valid   bit_in presented this cycle
//   bit_ready   monitor can accept a bit this cycle
//   byte_out    packed byte, first accepted bit in bit 7
//   byte_valid  byte_out holds an unconsumed byte
//   byte_ready  downstream consumes byte_out
//   clr_fail    pulse: clear failures and restart both tests
//   rct_fail    sticky RCT failure
//   apt_fail    sticky APT failure
//   healthy     no failure flagged
//   win_done    one-cycle pulse when an APT window completes
//   win_count   match count of the last completed window
// -----------------------------------------------------------------------------
module bit_stream_monitor #(
    parameter int unsigned WIN        = 64,
    parameter int unsigned RCT_CUTOFF = 8,
    parameter int unsigned APT_CUTOFF = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    input  logic                   clr_fail,
    output logic                   rct_fail,
    output logic                   apt_fail,
    output logic                   healthy,
    output logic                   win_done,
    output logic [$clog2(WIN):0]   win_count
);

    localparam int unsigned PW = $clog2(WIN);
    localparam int unsigned CW = PW + 1;

    localparam logic [7:0]    RCT_LIM  = 8'(RCT_CUTOFF);
    localparam logic [CW-1:0] APT_LIM  = CW'(APT_CUTOFF);
    localparam logic [PW-1:0] POS_LAST = PW'(WIN - 1);

    // Deserializer
    logic [6:0]    sh_q, sh_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          bvalid_q, bvalid_d;

    // RCT: rc == 0 means no bit seen since reset/clear
    logic          lb_q, lb_d;
    logic [7:0]    rc_q, rc_d;
    logic          rct_fail_q, rct_fail_d;

    // APT
    logic          rb_q, rb_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [CW-1:0] mc_q, mc_d;
    logic          apt_fail_q, apt_fail_d;
    logic          win_done_q, win_done_d;
    logic [CW-1:0] win_count_q, win_count_d;

    logic          accept;

    // Stall only when the last bit of a byte would overwrite an unconsumed byte.
    assign bit_ready = !(cnt_q == 3'd7 && bvalid_q && !byte_ready);
    assign accept    = bit_valid && bit_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves
        // it unassigned; otherwise a latch would be inferred.
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        bvalid_d    = bvalid_q;
        lb_d        = lb_q;
        rc_d        = rc_q;
        rct_fail_d  = rct_fail_q;
        rb_d        = rb_q;
        pos_d       = pos_q;
        mc_d        = mc_q;
        apt_fail_d  = apt_fail_q;
        win_done_d  = 1'b0;
        win_count_d = win_count_q;

        // Drain first; a load in the same cycle overrides it and keeps valid high.
        if (bvalid_q && byte_ready) begin
            bvalid_d = 1'b0;
        end

        // The deserializer runs regardless of clr_fail.
        if (accept) begin
            if (cnt_q == 3'd7) begin
                byte_d   = {sh_q, bit_in};
                bvalid_d = 1'b1;
                cnt_d    = 3'd0;
            end else begin
                sh_d  = {sh_q[5:0], bit_in};
                cnt_d = cnt_q + 3'd1;
            end
        end

        if (clr_fail) begin
            // Clear wins over anything the tests would do this cycle.
            rct_fail_d = 1'b0;
            apt_fail_d = 1'b0;
            rc_d       = 8'd0;
            pos_d      = '0;
            mc_d       = '0;
        end else if (accept) begin
            lb_d = bit_in;
            if (rc_q == 8'd0 || bit_in != lb_q) begin
                rc_d = 8'd1;
            end else if (rc_q != RCT_LIM) begin
                rc_d = rc_q + 8'd1;
            end
            if (rc_d == RCT_LIM) begin
                rct_fail_d = 1'b1;
            end

            if (pos_q == '0) begin
                rb_d = bit_in;
                mc_d = CW'(1);
            end else if (bit_in == rb_q) begin
                mc_d = mc_q + CW'(1);
            end
            // WIN is a power of two, so pos wraps to 0 on its own.
            pos_d = pos_q + PW'(1);
            if (pos_q == POS_LAST) begin
                win_done_d  = 1'b1;
                win_count_d = mc_d;
                if (mc_d >= APT_LIM) begin
                    apt_fail_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: there is no memory array here, so every register takes a reset
        // value; a partial byte or window is simply discarded.
        if (rst) begin
            sh_q        <= '0;
            cnt_q       <= '0;
            byte_q      <= '0;
            bvalid_q    <= 1'b0;
            lb_q        <= 1'b0;
            rc_q        <= '0;
            rct_fail_q  <= 1'b0;
            rb_q        <= 1'b0;
            pos_q       <= '0;
            mc_q        <= '0;
            apt_fail_q  <= 1'b0;
            win_done_q  <= 1'b0;
            win_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others.
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            bvalid_q    <= bvalid_d;
            lb_q        <= lb_d;
            rc_q        <= rc_d;
            rct_fail_q  <= rct_fail_d;
            rb_q        <= rb_d;
            pos_q       <= pos_d;
            mc_q        <= mc_d;
            apt_fail_q  <= apt_fail_d;
            win_done_q  <= win_done_d;
            win_count_q <= win_count_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = bvalid_q;
    assign rct_fail   = rct_fail_q;
    assign apt_fail   = apt_fail_q;
    assign healthy    = !rct_fail_q && !apt_fail_q;
    assign win_done   = win_done_q;
    assign win_count  = win_count_q;

endmodule

// File: tb/tb_bit_stream_monitor.sv
// -----------------------------------------------------------------------------
// tb_bit_stream_monitor
//
// Self-checking bench for bit_stream_monitor with default parameters. A
// behavioural model keeps the accepted bit history in queues and derives the
// byte stream, run lengths and window match counts from it directly.
// -----------------------------------------------------------------------------
module tb_bit_stream_monitor;

    localparam int WIN        = 64;
    localparam int RCT_CUTOFF = 8;
    localparam int APT_CUTOFF = 48;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       clr_fail;
    logic       rct_fail;
    logic       apt_fail;
    logic       healthy;
    logic       win_done;
    logic [6:0] win_count;

    int tests;
    int failed;

    bit_stream_monitor #(
        .WIN        (WIN),
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_CUTOFF (APT_CUTOFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .clr_fail   (clr_fail),
        .rct_fail   (rct_fail),
        .apt_fail   (apt_fail),
        .healthy    (healthy),
        .win_done   (win_done),
        .win_count  (win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit       partial[$];   // bits of the byte being assembled
    bit       hist[$];      // bits seen by the health tests since reset/clear
    bit [7:0] m_byte;
    bit       m_bvalid;
    bit       m_rct;
    bit       m_apt;
    bit       m_wd;
    int       m_wc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        partial.delete();
        hist.delete();
        m_byte   = 8'h00;
        m_bvalid = 1'b0;
        m_rct    = 1'b0;
        m_apt    = 1'b0;
        m_wd     = 1'b0;
        m_wc     = 0;
    endtask

    function automatic bit exp_ready(input bit br);
        return !(partial.size() == 7 && m_bvalid && !br);
    endfunction

    task automatic model_step(input bit acc, input bit b, input bit clr, input bit br);
        bit was_valid;
        was_valid = m_bvalid;
        m_wd = 1'b0;
        if (was_valid && br) m_bvalid = 1'b0;
        if (acc) begin
            partial.push_back(b);
            if (partial.size() == 8) begin
                for (int i = 0; i < 8; i++) m_byte = {m_byte[6:0], partial[i]};
                m_bvalid = 1'b1;
                partial.delete();
            end
        end
        if (clr) begin
            m_rct = 1'b0;
            m_apt = 1'b0;
            hist.delete();
        end else if (acc) begin
            int run;
            hist.push_back(b);
            run = 0;
            for (int i = hist.size() - 1; i >= 0 && run < RCT_CUTOFF; i--) begin
                if (hist[i] != b) break;
                run++;
            end
            if (run >= RCT_CUTOFF) m_rct = 1'b1;
            if (hist.size() % WIN == 0) begin
                int  base;
                int  cnt;
                bit  refb;
                base = hist.size() - WIN;
                refb = hist[base];
                cnt  = 0;
                for (int i = 0; i < WIN; i++) if (hist[base + i] == refb) cnt++;
                m_wc = cnt;
                m_wd = 1'b1;
                if (cnt >= APT_CUTOFF) m_apt = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("byte_valid", byte_valid, m_bvalid);
        check("byte_out",   byte_out,   m_byte);
        check("rct_fail",   rct_fail,   m_rct);
        check("apt_fail",   apt_fail,   m_apt);
        check("healthy",    healthy,    !m_rct && !m_apt);
        check("win_done",   win_done,   m_wd);
        check("win_count",  win_count,  m_wc);
    endtask

    // One clock of stimulus, entered and left at the falling edge.
    task automatic cycle(input bit v, input bit b, input bit br, input bit clr, output bit acc);
        bit_valid  = v;
        bit_in     = b;
        byte_ready = br;
        clr_fail   = clr;
        #1;
        check("bit_ready", bit_ready, exp_ready(br));
        acc = v && bit_ready;
        @(posedge clk);
        model_step(acc, b, clr, br);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic send(input bit b);
        bit acc;
        cycle(1'b1, b, 1'b1, 1'b0, acc);
        check("send_accepted", acc, 1'b1);
    endtask

    task automatic clear_tests();
        bit acc;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, acc);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        byte_ready = 1'b0;
        clr_fail   = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs();
        check("rst_bit_ready", bit_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit         acc;
        logic [15:0] bp_word;
        logic [7:0]  mo;
        int          ones_pct;

        tests  = 0;
        failed = 0;
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; byte_ready = 1'b0; clr_fail = 1'b0;
        @(negedge clk);
        do_reset();

        // Alternating stream: two 0xAA bytes, no failure.
        for (int i = 0; i < 16; i++) begin
            send(i % 2 == 0);
            if (i == 7 || i == 15) check("alt_byte", byte_out, 8'hAA);
        end
        check("alt_healthy", healthy, 1'b1);

        // RCT cutoff: 8 ones fail and stay failed through a following 0.
        clear_tests();
        for (int i = 0; i < 8; i++) send(1'b1);
        check("rct_8_ones", rct_fail, 1'b1);
        send(1'b0);
        check("rct_sticky", rct_fail, 1'b1);
        clear_tests();
        for (int i = 0; i < 7; i++) send(1'b1);
        send(1'b0);
        check("rct_7_ones", rct_fail, 1'b0);

        // APT cutoff: 1110 x16 gives 48 matches.
        clear_tests();
        for (int i = 0; i < 64; i++) send(i % 4 != 3);
        check("apt48_done",  win_done,  1'b1);
        check("apt48_count", win_count, 7'd48);
        check("apt48_fail",  apt_fail,  1'b1);
        check("apt48_rct",   rct_fail,  1'b0);
        // 47 ones with runs <= 3: 1110 x15 then 1100.
        clear_tests();
        for (int i = 0; i < 60; i++) send(i % 4 != 3);
        send(1'b1); send(1'b1); send(1'b0); send(1'b0);
        check("apt47_count", win_count, 7'd47);
        check("apt47_fail",  apt_fail,  1'b0);

        // Backpressure: 15 bits go in, the 16th waits for byte_ready.
        do_reset();
        bp_word = 16'($urandom());
        for (int k = 0; k < 15; k++) begin
            cycle(1'b1, bp_word[15-k], 1'b0, 1'b0, acc);
            check("bp_accept", acc, 1'b1);
            if (k == 7) check("bp_byte1", byte_out, bp_word[15:8]);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, bp_word[0], 1'b0, 1'b0, acc);
            check("bp_stalled", acc, 1'b0);
        end
        cycle(1'b1, bp_word[0], 1'b1, 1'b0, acc);
        check("bp_release", acc, 1'b1);
        check("bp_byte2_valid", byte_valid, 1'b1);
        check("bp_byte2", byte_out, bp_word[7:0]);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, acc);
        check("bp_drained", byte_valid, 1'b0);

        // clr_fail on the 8th repeated one wins over the failure.
        do_reset();
        for (int i = 0; i < 7; i++) send(1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, acc);
        check("clr_prio_rct", rct_fail, 1'b0);
        check("clr_prio_byte", byte_out, 8'hFF);
        for (int i = 0; i < 7; i++) send(1'b1);
        check("clr_restart_7", rct_fail, 1'b0);
        send(1'b1);
        check("clr_restart_8", rct_fail, 1'b1);

        // Reset mid-byte and mid-window.
        do_reset();
        for (int i = 0; i < 19; i++) send(1'($urandom_range(0, 1)));
        do_reset();
        check("mid_rst_valid", byte_valid, 1'b0);
        mo = 8'($urandom());
        for (int i = 0; i < 8; i++) send(mo[7-i]);
        check("mid_rst_byte", byte_out, mo);
        check("mid_rst_wc", win_count, 7'd0);
        for (int i = 0; i < 56; i++) send(1'($urandom_range(0, 1)));
        check("mid_rst_win", win_done, 1'b1);

        // Randomized traffic against the model.
        ones_pct = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ones_pct = 50;
                    1:       ones_pct = 85;
                    default: ones_pct = 15;
                endcase
            end
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 80,
                      $urandom_range(0, 99) < ones_pct,
                      $urandom_range(0, 99) < 70,
                      $urandom_range(0, 149) == 0,
                      acc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bit_stream_monitor.md
# bit_stream_monitor

Receive-side consumer for the single-bit pseudorandom stream produced by the dual-VILCG/comparator generator. It accepts one bit per handshake, packs bits MSB-first into bytes for downstream logic, and runs two online health tests on the same bits: a repetition-count test (RCT) and an adaptive-proportion test (APT). It sits directly after the generator's `z` output and gates whether the generated stream is trusted.

## Interface
- `WIN`, 64: APT window length in bits; power of two, at least 8.
- `RCT_CUTOFF`, 8: run length of identical bits that flags an RCT failure; 2..255.
- `APT_CUTOFF`, 48: reference-bit match count within one window that flags an APT failure; at most `WIN`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `bit_in` input 1: stream bit, normally the generator's `z`.
- `bit_valid` input 1: `bit_in` is presented this cycle.
- `bit_ready` output 1: the monitor can accept a bit this cycle.
- `byte_out` output 8: packed byte; the first accepted bit lands in bit 7.
- `byte_valid` output 1: `byte_out` holds an unconsumed byte.
- `byte_ready` input 1: downstream consumes `byte_out`.
- `clr_fail` input 1: one-cycle pulse that clears failures and restarts both tests.
- `rct_fail` output 1: sticky RCT failure.
- `apt_fail` output 1: sticky APT failure.
- `healthy` output 1: `!rct_fail && !apt_fail`.
- `win_done` output 1: one-cycle pulse when an APT window completes.
- `win_count` output clog2(`WIN`)+1: match count of the last completed window.

## Operation
- **Bit acceptance.** A bit is accepted when `bit_valid && bit_ready`. Nothing changes on a cycle with no acceptance, except the byte drain and `clr_fail`.
- **Deserializer state.** A 7-bit shift register `sh` and a 3-bit count `cnt` (0..7).
- **Bits 1 to 7 of a byte.** On acceptance with `cnt < 7`: `sh <= {sh[5:0], bit_in}` and `cnt` increments.
- **Bit 8 of a byte.** On acceptance with `cnt == 7`: `byte_out <= {sh, bit_in}`, `byte_valid <= 1` and `cnt <= 0`.
- **Byte drain.** If `byte_valid && byte_ready` and no byte is loaded in the same cycle, `byte_valid <= 0`. A load and a drain in the same cycle replace the byte, and `byte_valid` stays 1.
- **Ready rule.** `bit_ready = !(cnt == 7 && byte_valid && !byte_ready)`. This is combinational from registered state and `byte_ready`. No bit is ever dropped.
- **RCT.** State is the last bit `lb` and a run counter `rc` that saturates at `RCT_CUTOFF`.
  - The first accepted bit after reset or a clear sets `rc = 1`.
  - A later bit equal to `lb` increments `rc`; a different bit sets `rc = 1`.
  - When `rc` becomes `RCT_CUTOFF`, `rct_fail <= 1`.
- **APT.** State is the reference bit `rb`, a position counter `pos` (0..`WIN`-1) and a match counter `mc`.
  - With `pos == 0`, the accepted bit sets `rb` and `mc = 1`.
  - Otherwise, `mc` increments if the bit equals `rb`.
  - On the bit with `pos == WIN-1`: `win_count <= final mc` and `win_done <= 1` for one cycle. `apt_fail <= 1` if the final `mc >= APT_CUTOFF`. `pos` wraps to 0, so the next bit starts a new window.
- **Sticky failures.** `rct_fail` and `apt_fail` stay set until `rst` or `clr_fail`.
- **`clr_fail`.**
  - Clears both fail flags.
  - Restarts the RCT (next bit is treated as first) and sets `pos = 0`, `mc = 0`.
  - Has priority over a failure or window completion in the same cycle. That cycle's test update is discarded and `win_done` stays 0.
  - The bit accepted that cycle still enters the deserializer.
- **`rst`.** Clears everything, mid-byte and mid-window included. A partial byte is discarded and `cnt = 0`.

## Timing
- **Reset values.** `byte_out` = 0, `byte_valid` = 0, `rct_fail` = 0, `apt_fail` = 0, `win_done` = 0, `win_count` = 0. `healthy` = 1 and `bit_ready` = 1 after reset.
- **Byte latency.** `byte_valid` rises the cycle after the 8th bit of a byte is accepted.
- **Failure latency.** Each fail flag rises the cycle after the offending bit is accepted. `win_done` pulses the cycle after the `WIN`-th bit of a window.
- **Throughput.** One bit per cycle sustained while `byte_ready` is held high.
- **Stall.** When the output register is full and the shift register holds 7 bits, `bit_ready` is 0 until the cycle `byte_ready` is 1. The 8th bit is accepted in that same cycle.

## Test plan
- **Alternating stream.** `rst`, then 16 bits 1,0,1,0,… one per cycle with `byte_ready` = 1 → `byte_out` = 0xAA twice; `healthy` stays 1; `rct_fail` = 0.
- **RCT cutoff.** Defaults; 8 consecutive 1s → `rct_fail` = 1 the cycle after the 8th bit, and it stays set through a following 0. Separately, 7 ones then a 0 → `rct_fail` = 0.
- **APT cutoff.** Defaults; the pattern 1,1,1,0 repeated 16 times → `win_done` pulses, `win_count` = 48, `apt_fail` = 1, `rct_fail` = 0. Separately, a 64-bit window starting with 1 and containing 47 ones with runs ≤ 3 → `win_count` = 47, `apt_fail` = 0.
- **Backpressure.** `byte_ready` = 0 and 16 bits offered back-to-back → `bit_ready` drops after the 15th acceptance and the 16th bit waits. Raising `byte_ready` → the first byte is consumed and the 16th is accepted in the same cycle; the second byte appears next cycle with no bit lost or duplicated.
- **`clr_fail` priority.** `clr_fail` pulsed in the same cycle as the 8th repeated 1 → `rct_fail` stays 0; that bit still appears in `byte_out`; the RCT restarts with `rc` = 1 on the next bit.
- **Reset mid-operation.** `rst` after 3 bits and mid-window → `byte_valid` = 0. The next 8 bits form a complete byte by themselves; `win_count` is unchanged from 0 until a full 64-bit window completes.
